// File: rtl/tag_tx_pkg.sv
// Shared constants and types for the photon time-tag packetizer.
package tag_tx_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         FLAG_OVF_BIT  = 7;
  localparam int         FLAG_CHAN_LSB = 0;

  // CSUM is only reached when TAG_TX_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    HOLD = 3'd3,
    CSUM = 3'd4
  } state_e;

  // Flags byte: drop indicator on top, detector channel at the bottom.
  function automatic logic [7:0] flags_byte(input logic ovf, input logic [1:0] chan);
    logic [7:0] f;
    f = '0;
    f[FLAG_OVF_BIT] = ovf;
    f[FLAG_CHAN_LSB +: 2] = chan;
    return f;
  endfunction

endpackage

// File: rtl/tag_tx_packetizer_if.sv
// Tag input strobe plus the transmitter start/data/busy handshake.
interface tag_tx_packetizer_if #(parameter int TAG_W = 32);
  logic             tag_valid;
  logic [TAG_W-1:0] tag_time;
  logic [1:0]       tag_chan;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;

  // Environment side: tag source and UART transmitter.
  modport master (output tag_valid, tag_time, tag_chan, tx_busy,
                  input  tx_start, tx_data);
  // Packetizer side.
  modport slave  (input  tag_valid, tag_time, tag_chan, tx_busy,
                  output tx_start, tx_data);
endinterface

// File: rtl/tag_fifo.sv
// Synchronous tag FIFO with occupancy count; head entry is shown combinationally.
module tag_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          wr_en, rd_en;

  // Fullness is judged on the registered level, i.e. before any same-cycle pop.
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rptr];

  // Storage array, no reset needed: only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tag_tx_packetizer.sv
// Photon time-tag packetizer: buffers tags and feeds them byte-wise to the
// RS-232 transmitter as {A5, flags, time LSB-first [, xor checksum]}.
// Optional feature macro: TAG_TX_CHECKSUM_EN appends an XOR checksum byte.
module tag_tx_packetizer
  import tag_tx_pkg::*;
#(
  parameter int TAG_W      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  tag_tx_packetizer_if.slave          bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        pkt_active
);

  localparam int NB = TAG_W / 8;
`ifdef TAG_TX_CHECKSUM_EN
  localparam int PKT_LEN = NB + 3;
`else
  localparam int PKT_LEN = NB + 2;
`endif
  localparam int IW        = $clog2(PKT_LEN);
  localparam int LAST_DATA = NB + 1;

  state_e                       state;
  logic [IW-1:0]                idx;
  logic [TAG_W-1:0]             pkt_time;
  logic [1:0]                   pkt_chan;
  logic                         ovf_q;
  logic [TAG_W-1:0]             head_time;
  logic [1:0]                   head_chan;
  logic                         full, empty, push, drop, pop;
  logic [7:0]                   flags;
  logic [PKT_LEN-1:0][7:0]      pkt_bytes;
  logic                         sending;

  assign push = bus.tag_valid && !full;
  assign drop = bus.tag_valid && full;
  assign pop  = (state == LOAD);

  tag_fifo #(.W(TAG_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.tag_chan, bus.tag_time}),
    .rdata ({head_chan, head_time}),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign flags = flags_byte(ovf_q, pkt_chan);

  // Assemble the whole packet from the packet register; idx selects the byte.
  always_comb begin
    pkt_bytes    = '0;
    pkt_bytes[0] = SYNC_BYTE;
    pkt_bytes[1] = flags;
    for (int i = 0; i < NB; i++) pkt_bytes[i + 2] = pkt_time[8*i +: 8];
`ifdef TAG_TX_CHECKSUM_EN
    pkt_bytes[PKT_LEN-1] = flags;
    for (int i = 0; i < NB; i++) pkt_bytes[PKT_LEN-1] ^= pkt_time[8*i +: 8];
`endif
  end

  // Start pulse is combinational so it drops at the reset edge and never
  // fires against a busy transmitter.
  assign sending      = (state == SEND) || (state == CSUM);
  assign bus.tx_start = sending && !bus.tx_busy;
  assign bus.tx_data  = (sending || state == HOLD) ? pkt_bytes[idx] : 8'h00;
  assign pkt_active   = (state != IDLE);

  // Sticky drop flag; a drop in the LOAD cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (state == LOAD)  overflow <= 1'b0;
  end

  // Packet sequencer: load head, then SEND/HOLD per byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      pkt_time <= '0;
      pkt_chan <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) state <= LOAD;
        LOAD: begin
          pkt_time <= head_time;
          pkt_chan <= head_chan;
          ovf_q    <= overflow;
          idx      <= '0;
          state    <= SEND;
        end
        SEND, CSUM: if (!bus.tx_busy) state <= HOLD;
        // One dead cycle: transmitter busy rises a cycle after start.
        HOLD: begin
          if (idx == IW'(PKT_LEN - 1)) begin
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
`ifdef TAG_TX_CHECKSUM_EN
            state <= (idx == IW'(LAST_DATA)) ? CSUM : SEND;
`else
            state <= SEND;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
